output_controller: RTL and testbench
====================================

# output_controller

Processor-to-game output block: the counterpart of the push-button input controller. The CPU's memory-mapped stores set the player position and score and post bullet-spawn requests. The block holds these values for the renderer side, queues spawn requests in a small FIFO, and stretches a one-cycle score-change event into a visible LED pulse. It sits between the processor's store path and the VGA/renderer and LED logic.

## Interface
Parameters:
- SCREEN_W, 640: horizontal pixel count; player position is clamped to 0..SCREEN_W-1.
- FIFO_DEPTH, 4: bullet-request queue depth; must be a power of two, at least 2.
- HIT_CYCLES, 25000000: length of the stretched hit pulse, in clocks; at least 1.

Ports (one clock; reset is asynchronous and active-high):
- clock, in, 1: system clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- wren, in, 1: CPU store strobe, one cycle per store.
- addr, in, 2: register select.
- wdata, in, 32: store data.
- playerX, out, 10: clamped player column.
- score, out, 16: current score.
- bulletValid, out, 1: head of the bullet FIFO is valid.
- bulletX, out, 10: column of the head entry.
- bulletReady, in, 1: renderer accepts the head entry.
- fifoFull, out, 1: FIFO at capacity; the CPU polls this before posting.
- hitLed, out, 1: stretched score-change pulse.
- dropCount, out, 8: count of rejected bullet posts.

## Operation
- Register map, acted on only when wren=1:
  - addr 0: player position. wdata is signed 32-bit. Negative values give playerX=0. Values ≥ SCREEN_W give SCREEN_W-1. Otherwise playerX=wdata[9:0].
  - addr 1: bullet post. Push wdata[9:0] if not full. When full, the post is dropped, the FIFO is unchanged, and dropCount increments, saturating at 255.
  - addr 2: score write. score=wdata[15:0]. If the new value differs from the old one, the hit counter loads HIT_CYCLES.
  - addr 3: control. wdata[0]=1 clears dropCount; wdata[1]=1 clears hitLed and its counter immediately. Other bits are ignored.
- Hit stretcher: a down-counter. hitLed=1 while the counter is non-zero; it decrements once per clock. A reload while already counting restarts the count at HIT_CYCLES.
- FIFO handshake:
  - A transfer occurs when bulletValid and bulletReady are both 1 at a rising edge.
  - bulletX is stable while bulletValid=1 and no transfer has occurred.
  - bulletReady while empty has no effect.
- Simultaneous push and pop:
  - Not full: both occur and the occupancy is unchanged.
  - Full: the pop frees a slot, so the push is accepted with no drop. fifoFull here is the pre-edge occupancy combined with the same-cycle pop.
- Pointers wrap modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- Reset, at any time including mid-pulse or with a partly filled FIFO:
  - playerX=0, score=0, FIFO empty, bulletValid=0, bulletX=0.
  - fifoFull=0, hitLed=0, counter=0, dropCount=0.

## Timing
- All outputs are registered except fifoFull and bulletX. fifoFull is decoded from occupancy; bulletX is read from the head slot.
- A store on edge N is visible on playerX and score after edge N.
- A push into an empty FIFO raises bulletValid after the same edge. There is no same-cycle fall-through.
- hitLed rises the cycle after the score-change edge and stays high for exactly HIT_CYCLES cycles.
- fifoFull reflects occupancy after each edge. A post in the cycle fifoFull rises is dropped.

## Configuration
- OUTCTRL_DROP_COUNT_EN:
  - Defined: dropCount logic as described above.
  - Undefined: dropCount is tied to 0, no counter is synthesized, the addr 3 bit 0 clear is ignored, and drops are silent.

## Structure
- Shared package (output_ctrl_pkg) holds:
  - Address constants: ADDR_PLAYER=0, ADDR_BULLET=1, ADDR_SCORE=2, ADDR_CTRL=3.
  - Control bit indices: CTRL_CLR_DROP=0, CTRL_CLR_HIT=1.
  - Widths: X_W=10, SCORE_W=16, DROP_W=8.
- One sub-module, bullet_fifo: parameterised depth and width, with push, pop, full, valid, and head data. Clamp, score, stretcher and drop logic stay in the top level.

## Test plan
- Clamping: reset, then store addr 0 with values 0xFFFFFFEC, 300, then 700 → playerX reads 0, then 300, then 639, each one cycle after its store.
- FIFO order: with bulletReady=0, post 5, 6, 7, 8 → fifoFull=1 and bulletValid=1 with bulletX=5. Raise bulletReady for 4 cycles → the renderer sees 5, 6, 7, 8, then bulletValid=0.
- Drop behaviour: with the FIFO full, post 9 twice → dropCount=2 and the head is still 5. Store addr 3 with wdata=1 → dropCount=0. Without OUTCTRL_DROP_COUNT_EN, dropCount stays 0.
- Push and pop together: with the FIFO full, post 10 in the same cycle bulletReady=1 → no drop, occupancy stays 4, and 10 drains last.
- Hit pulse with HIT_CYCLES=5: store score 3 → hitLed is high for exactly 5 cycles. Storing 3 again gives no pulse. Storing 4 mid-pulse restarts the count to 5. Storing addr 3 with wdata=2 clears hitLed on the next cycle.
- Reset mid-operation: assert reset asynchronously between edges with the FIFO half full and hitLed high → all outputs go to their reset values immediately without waiting for a clock edge. The first post after release appears after one edge.

Source files
------------

// File: rtl/output_ctrl_pkg.sv
// Shared constants for the processor-to-game output block: register map,
// control bit positions, field widths and the player-column clamp helper.
package output_ctrl_pkg;

  // Store register map
  localparam logic [1:0] ADDR_PLAYER = 2'd0;
  localparam logic [1:0] ADDR_BULLET = 2'd1;
  localparam logic [1:0] ADDR_SCORE  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // Control register bit positions
  localparam int unsigned CTRL_CLR_DROP = 0;
  localparam int unsigned CTRL_CLR_HIT  = 1;

  // Field widths
  localparam int unsigned X_W     = 10;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned DROP_W  = 8;

  // Clamp a signed 32-bit store value into the visible column range.
  function automatic logic [X_W-1:0] clampX(input logic [31:0] value, input int unsigned screenW);
    if (value[31]) begin
      return '0;
    end else if (value >= 32'(screenW)) begin
      return X_W'(screenW - 1);
    end else begin
      return value[X_W-1:0];
    end
  endfunction

endpackage

// File: rtl/output_controller_if.sv
// CPU store path plus renderer/LED outputs of the output controller.
// master: CPU/renderer side; slave: the controller itself.
interface output_controller_if;
  import output_ctrl_pkg::*;

  logic               wren;
  logic [1:0]         addr;
  logic [31:0]        wdata;
  logic [X_W-1:0]     playerX;
  logic [SCORE_W-1:0] score;
  logic               bulletValid;
  logic [X_W-1:0]     bulletX;
  logic               bulletReady;
  logic               fifoFull;
  logic               hitLed;
  logic [DROP_W-1:0]  dropCount;

  modport master (
    output wren, addr, wdata, bulletReady,
    input  playerX, score, bulletValid, bulletX, fifoFull, hitLed, dropCount
  );

  modport slave (
    input  wren, addr, wdata, bulletReady,
    output playerX, score, bulletValid, bulletX, fifoFull, hitLed, dropCount
  );

endinterface

// File: rtl/bullet_fifo.sv
// Small synchronous FIFO for bullet-spawn requests. No fall-through: a push
// into an empty queue becomes visible after the edge. A pop in the same
// cycle frees a slot, so a push while full is accepted when pop fires.
module bullet_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] pushData,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [Width-1:0] headData
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  rdPtr;
  logic [PtrW-1:0]  wrPtr;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  countNext;
  logic             popFire;
  logic             pushFire;

  // Handshake qualification and occupancy update
  always_comb begin
    popFire  = pop && valid;
    pushFire = push && (!full || popFire);
    countNext = count;
    if (pushFire && !popFire) begin
      countNext = count + 1'b1;
    end else if (popFire && !pushFire) begin
      countNext = count - 1'b1;
    end
  end

  assign full     = (count == CntW'(Depth));
  assign headData = mem[rdPtr];

  // Storage, pointers (wrap naturally at power-of-two depth), registered valid
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      if (pushFire) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (popFire) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count <= countNext;
      valid <= (countNext != '0);
    end
  end

endmodule

// File: rtl/output_controller.sv
// Processor-to-game output block: holds player column and score written by
// CPU stores, queues bullet-spawn posts, and stretches score changes into a
// visible LED pulse.
// Optional feature macro: OUTCTRL_DROP_COUNT_EN enables the saturating count
// of bullet posts rejected while the queue is full.
module output_controller
  import output_ctrl_pkg::*;
#(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HIT_CYCLES = 25000000
) (
  input logic                clock,
  input logic                reset,
  output_controller_if.slave bus
);

  localparam int unsigned HitW = $clog2(HIT_CYCLES + 1);

  logic               wrPlayer;
  logic               wrBullet;
  logic               wrScore;
  logic               wrCtrl;
  logic               scoreChange;
  logic               clrHit;
  logic [X_W-1:0]     playerXQ;
  logic [SCORE_W-1:0] scoreQ;
  logic [HitW-1:0]    hitCount;
  logic [HitW-1:0]    hitCountNext;
  logic               hitLedQ;

  // Register-select decode
  always_comb begin
    wrPlayer    = bus.wren && (bus.addr == ADDR_PLAYER);
    wrBullet    = bus.wren && (bus.addr == ADDR_BULLET);
    wrScore     = bus.wren && (bus.addr == ADDR_SCORE);
    wrCtrl      = bus.wren && (bus.addr == ADDR_CTRL);
    scoreChange = wrScore && (bus.wdata[SCORE_W-1:0] != scoreQ);
    clrHit      = wrCtrl && bus.wdata[CTRL_CLR_HIT];
  end

  // Player column and score holding registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      playerXQ <= '0;
      scoreQ   <= '0;
    end else begin
      if (wrPlayer) begin
        playerXQ <= clampX(bus.wdata, SCREEN_W);
      end
      if (wrScore) begin
        scoreQ <= bus.wdata[SCORE_W-1:0];
      end
    end
  end

  // Hit stretcher next count: reload beats clear beats decrement
  always_comb begin
    hitCountNext = hitCount;
    if (hitCount != '0) begin
      hitCountNext = hitCount - 1'b1;
    end
    if (clrHit) begin
      hitCountNext = '0;
    end
    if (scoreChange) begin
      hitCountNext = HitW'(HIT_CYCLES);
    end
  end

  // Hit stretcher state; LED registered from the next count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hitCount <= '0;
      hitLedQ  <= 1'b0;
    end else begin
      hitCount <= hitCountNext;
      hitLedQ  <= (hitCountNext != '0);
    end
  end

  bullet_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (X_W)
  ) u_bullet_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (wrBullet),
    .pushData (bus.wdata[X_W-1:0]),
    .pop      (bus.bulletReady),
    .full     (bus.fifoFull),
    .valid    (bus.bulletValid),
    .headData (bus.bulletX)
  );

`ifdef OUTCTRL_DROP_COUNT_EN
  logic              dropPost;
  logic [DROP_W-1:0] dropCountQ;

  // A post is lost only when full and no pop frees a slot this cycle
  assign dropPost = wrBullet && bus.fifoFull && !(bus.bulletReady && bus.bulletValid);

  // Saturating drop counter with CPU clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dropCountQ <= '0;
    end else if (wrCtrl && bus.wdata[CTRL_CLR_DROP]) begin
      dropCountQ <= '0;
    end else if (dropPost && (dropCountQ != '1)) begin
      dropCountQ <= dropCountQ + 1'b1;
    end
  end

  assign bus.dropCount = dropCountQ;
`else
  assign bus.dropCount = '0;
`endif

  assign bus.playerX = playerXQ;
  assign bus.score   = scoreQ;
  assign bus.hitLed  = hitLedQ;

endmodule

// File: tb/tb_output_controller.sv
// Self-checking bench for output_controller. Inputs change on the falling
// edge; outputs are sampled on the falling edge. Bullet posts feed a
// scoreboard queue that is popped and compared on each renderer transfer.
module tb_output_controller;
  import output_ctrl_pkg::*;

  localparam int unsigned Depth     = 4;
  localparam int unsigned HitCycles = 5;

  logic clock = 1'b0;
  logic reset;

  output_controller_if bus ();

  output_controller #(
    .SCREEN_W   (640),
    .FIFO_DEPTH (Depth),
    .HIT_CYCLES (HitCycles)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int         checks   = 0;
  int         failures = 0;
  logic [9:0] expQ[$];
  int         expDrop  = 0;

  function automatic int expDropVal();
`ifdef OUTCTRL_DROP_COUNT_EN
    return expDrop;
`else
    return 0;
`endif
  endfunction

  // One clock: scoreboard the transfer/post at this edge, then check after it
  task automatic tick();
    logic       fire;
    logic [9:0] e;
    fire = bus.bulletValid && bus.bulletReady;
    checks++;
    if (bus.bulletValid !== logic'(expQ.size() != 0)) begin
      failures++;
      $display("FAIL valid: got %0b expected %0b", bus.bulletValid, expQ.size() != 0);
    end
    if (fire) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL pop_empty: got bulletX %0d expected no transfer", bus.bulletX);
      end else begin
        e = expQ.pop_front();
        if (bus.bulletX !== e) begin
          failures++;
          $display("FAIL order: got bulletX %0d expected %0d", bus.bulletX, e);
        end
      end
    end
    if (bus.wren && bus.addr == ADDR_BULLET) begin
      if (expQ.size() < int'(Depth)) expQ.push_back(bus.wdata[9:0]);
      else if (expDrop < 255) expDrop++;
    end
    if (bus.wren && bus.addr == ADDR_CTRL && bus.wdata[0]) expDrop = 0;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.fifoFull !== logic'(expQ.size() == int'(Depth))) begin
      failures++;
      $display("FAIL full: got %0b expected %0b", bus.fifoFull, expQ.size() == int'(Depth));
    end
    checks++;
    if (int'(bus.dropCount) != expDropVal()) begin
      failures++;
      $display("FAIL drop_count: got %0d expected %0d", bus.dropCount, expDropVal());
    end
  endtask

  task automatic post(input logic [1:0] a, input logic [31:0] d);
    bus.wren  = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.wren  = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.wren        = 1'b0;
    bus.addr        = '0;
    bus.wdata       = '0;
    bus.bulletReady = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({bus.playerX, bus.score, bus.bulletValid, bus.bulletX, bus.fifoFull, bus.hitLed,
         bus.dropCount} !== '0) begin
      failures++;
      $display("FAIL reset_state: got px=%0d sc=%0d v=%0b bx=%0d f=%0b h=%0b d=%0d expected all 0",
               bus.playerX, bus.score, bus.bulletValid, bus.bulletX, bus.fifoFull, bus.hitLed,
               bus.dropCount);
    end
  endtask

  task automatic test_clamp();
    logic [31:0] vals [3];
    logic [9:0]  exps [3];
    vals = '{32'hFFFF_FFEC, 32'd300, 32'd700};
    exps = '{10'd0, 10'd300, 10'd639};
    for (int i = 0; i < 3; i++) begin
      post(ADDR_PLAYER, vals[i]);
      checks++;
      if (bus.playerX !== exps[i]) begin
        failures++;
        $display("FAIL clamp_%0d: got %0d expected %0d", i, bus.playerX, exps[i]);
      end
    end
  endtask

  task automatic test_fifo_order();
    bus.bulletReady = 1'b0;
    for (int i = 5; i <= 8; i++) post(ADDR_BULLET, 32'(i));
    checks++;
    if (bus.fifoFull !== 1'b1 || bus.bulletValid !== 1'b1 || bus.bulletX !== 10'd5) begin
      failures++;
      $display("FAIL fill: got f=%0b v=%0b bx=%0d expected 1 1 5",
               bus.fifoFull, bus.bulletValid, bus.bulletX);
    end
    bus.bulletReady = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.bulletReady = 1'b0;
    checks++;
    if (bus.bulletValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("FAIL drained: got v=%0b left=%0d expected 0 0", bus.bulletValid, expQ.size());
    end
  endtask

  task automatic test_drop();
    for (int i = 5; i <= 8; i++) post(ADDR_BULLET, 32'(i));
    post(ADDR_BULLET, 32'd9);
    post(ADDR_BULLET, 32'd9);
    checks++;
    if (int'(bus.dropCount) != expDropVal() || bus.bulletX !== 10'd5) begin
      failures++;
      $display("FAIL drop_two: got d=%0d bx=%0d expected %0d 5",
               bus.dropCount, bus.bulletX, expDropVal());
    end
    post(ADDR_CTRL, 32'd1);
    checks++;
    if (bus.dropCount !== 8'd0) begin
      failures++;
      $display("FAIL drop_clear: got %0d expected 0", bus.dropCount);
    end
  endtask

  task automatic test_push_pop();
    // Queue is full with 5..8 here
    bus.bulletReady = 1'b1;
    post(ADDR_BULLET, 32'd10);
    checks++;
    if (bus.fifoFull !== 1'b1 || bus.dropCount !== 8'd0) begin
      failures++;
      $display("FAIL push_pop_full: got f=%0b d=%0d expected 1 0", bus.fifoFull, bus.dropCount);
    end
    for (int i = 0; i < 4; i++) tick();
    bus.bulletReady = 1'b0;
    checks++;
    if (bus.bulletValid !== 1'b0 || expQ.size() != 0) begin
      failures++;
      $display("FAIL push_pop_drain: got v=%0b left=%0d expected 0 0",
               bus.bulletValid, expQ.size());
    end
  endtask

  task automatic test_hit();
    int n;
    post(ADDR_SCORE, 32'd3);
    checks++;
    if (bus.score !== 16'd3) begin
      failures++;
      $display("FAIL score: got %0d expected 3", bus.score);
    end
    n = 0;
    while (bus.hitLed === 1'b1 && n < 20) begin n++; tick(); end
    checks++;
    if (n != int'(HitCycles)) begin
      failures++;
      $display("FAIL hit_len: got %0d expected %0d", n, HitCycles);
    end
    post(ADDR_SCORE, 32'd3);
    tick();
    checks++;
    if (bus.hitLed !== 1'b0) begin
      failures++;
      $display("FAIL hit_same: got %0b expected 0", bus.hitLed);
    end
    post(ADDR_SCORE, 32'd4);
    tick();
    tick();
    post(ADDR_SCORE, 32'd9);
    n = 0;
    while (bus.hitLed === 1'b1 && n < 20) begin n++; tick(); end
    checks++;
    if (n != int'(HitCycles)) begin
      failures++;
      $display("FAIL hit_restart: got %0d expected %0d", n, HitCycles);
    end
    post(ADDR_SCORE, 32'd1);
    tick();
    post(ADDR_CTRL, 32'd2);
    checks++;
    if (bus.hitLed !== 1'b0) begin
      failures++;
      $display("FAIL hit_clear: got %0b expected 0", bus.hitLed);
    end
  endtask

  task automatic test_reset_mid();
    bus.bulletReady = 1'b0;
    post(ADDR_BULLET, 32'd21);
    post(ADDR_BULLET, 32'd22);
    post(ADDR_SCORE, 32'd77);
    checks++;
    if (bus.hitLed !== 1'b1 || bus.bulletValid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got h=%0b v=%0b expected 1 1", bus.hitLed, bus.bulletValid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.playerX, bus.score, bus.bulletValid, bus.bulletX, bus.fifoFull, bus.hitLed,
         bus.dropCount} !== '0) begin
      failures++;
      $display("FAIL async_reset: got px=%0d sc=%0d v=%0b bx=%0d f=%0b h=%0b d=%0d expected all 0",
               bus.playerX, bus.score, bus.bulletValid, bus.bulletX, bus.fifoFull, bus.hitLed,
               bus.dropCount);
    end
    @(negedge clock);
    reset = 1'b0;
    expQ.delete();
    expDrop = 0;
    post(ADDR_BULLET, 32'd33);
    checks++;
    if (bus.bulletValid !== 1'b1 || bus.bulletX !== 10'd33) begin
      failures++;
      $display("FAIL post_after_reset: got v=%0b bx=%0d expected 1 33",
               bus.bulletValid, bus.bulletX);
    end
    bus.bulletReady = 1'b1;
    tick();
    tick();
    bus.bulletReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clamp();
    test_fifo_order();
    test_drop();
    test_push_pop();
    test_hit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
